// File: rtl/clk_div_multi_pkg.sv
// rtl/clk_div_multi_pkg.sv - shared constants and helpers for the multi-channel clock divider
//
// Purpose : default divider width/divisor and the channel-index width helper.
// Contents: DIV_W_DEF, DEFAULT_DIV_DEF, ch_idx_w().
package clk_div_pkg;

  localparam int DIV_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 333;

  // Width of a channel index; a single-channel build still gets a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_multi_channel.sv
// rtl/clk_div_multi_channel.sv - one divider channel: counter, active/shadow divisor, output toggle
//
// Purpose : divides clk by 2*active_div, producing a registered square wave and a
//           one-cycle tick on every toggle. A written divisor waits in a shadow
//           register and is applied at the next terminal count.
// Ports   : clk, reset (async, active-low)
//           en        - count enable; 0 holds counter/output and forces tick low
//           wr_sel    - write strobe already decoded for this channel
//           wr_div    - new half-period divisor
//           sync_clr  - phase-align: clear counter/output, apply pending shadow
//           clk_out, tick, pending - registered outputs
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr_sel,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             sync_clr,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_act;
  logic [DIV_W-1:0] r_shd;
  logic             r_out;
  logic             r_tick;
  logic             r_pend;

  logic w_idle;
  logic w_term;

  // A zero divisor parks the channel; the compare path is only used when active.
  assign w_idle = (r_act == '0);
  assign w_term = !w_idle && (r_cnt == (r_act - DIV_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_act  <= DEF_DIV;
      r_shd  <= DEF_DIV;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (sync_clr || w_idle) begin
        // Idle channels pick up a pending divisor on the next cycle, even with en low.
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
        if (r_pend) begin
          r_act  <= r_shd;
          r_pend <= 1'b0;
        end
      end else if (en) begin
        if (w_term) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          if (r_pend) begin
            r_act  <= r_shd;
            r_pend <= 1'b0;
            // Switching to idle parks the output low instead of toggling.
            r_out  <= (r_shd == '0) ? 1'b0 : ~r_out;
          end else begin
            r_out <= ~r_out;
          end
        end else begin
          r_cnt  <= r_cnt + DIV_W'(1);
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end

      // Written last so a write coinciding with an apply keeps the new value
      // pending while the previous shadow is the one that takes effect.
      if (wr_sel) begin
        r_shd  <= wr_div;
        r_pend <= 1'b1;
      end
    end
  end

  assign clk_out = r_out;
  assign tick    = r_tick;
  assign pending = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock-enable/divider generator
//
// Purpose : CHANNELS independent dividers, each producing a 50 % square wave of
//           period 2*divisor clk cycles plus a tick on every toggle.
// Ports   : clk, reset (async, active-low), en (global count enable)
//           wr_en/wr_ch/wr_div - divisor write; wr_ch >= CHANNELS is ignored
//           sync_clr           - only with CLK_DIV_MULTI_SYNC_EN defined
//           clk_out, tick, pending - one bit per channel
// Macro   : CLK_DIV_MULTI_SYNC_EN adds sync_clr to phase-align all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W       = ch_idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [DIV_W-1:0]    wr_div,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic                sync_clr,
`endif
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [CHANNELS-1:0] w_wr_sel;
  logic                w_sync;

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign w_sync = sync_clr;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Out-of-range channel numbers match no decoder bit and are dropped.
    assign w_wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .wr_sel   (w_wr_sel[i]),
      .wr_div   (wr_div),
      .sync_clr (w_sync),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock-enable/divider generator. Successor to the fixed single-ratio divider.
- Each channel derives a 50 % square wave and a one-cycle tick from the 100 MHz system clock.
- Divisors are runtime-writable; a new divisor takes effect glitch-free at the channel's next terminal count.
- Feeds sample-rate strobes, e.g. 150 kHz, to the recursive filter and peripheral timing.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- DIV_W, 16, width of the divisor and counter per channel.
- DEFAULT_DIV, 333, divisor loaded into every channel at reset; output period = 2*DEFAULT_DIV clk cycles.

Ports:
- clk  in  1  system clock, 100 MHz; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  global count enable; when 0, all counters, outputs and ticks hold (tick forced 0).
- wr_en  in  1  divisor write strobe, one cycle.
- wr_ch  in  $clog2(CHANNELS) (min 1)  target channel of write.
- wr_div  in  DIV_W  new half-period divisor.
- clk_out  out  CHANNELS  divided square wave per channel, registered.
- tick  out  CHANNELS  one-cycle pulse coincident with every clk_out toggle, registered.
- pending  out  CHANNELS  1 = shadow divisor written but not yet applied.

Behaviour:
- Reset (reset=0, async): counter=0, clk_out=0, tick=0, pending=0, active_div=shadow_div=DEFAULT_DIV, all channels.
- Per channel, en=1, active_div=D>0:
  - counter runs 0..D-1.
  - On the cycle counter==D-1: counter<=0, clk_out<=~clk_out, tick<=1. Otherwise tick<=0.
  - Output period = 2*D cycles. D=1 toggles clk_out every cycle (clk/2, tick constantly 1).
- Write: wr_en=1 with wr_ch<CHANNELS sets shadow_div<=wr_div and pending<=1 on that channel.
  - wr_ch>=CHANNELS is ignored silently.
  - Writes are accepted regardless of en.
- Apply: at a terminal-count cycle with pending=1, active_div<=shadow_div and pending<=0. The toggle and tick still occur on that cycle.
- Simultaneous write and terminal count on the same channel:
  - The shadow value present before the write is applied.
  - The newly written value lands in shadow_div.
  - pending stays 1, and the new value applies at the following terminal count.
- Back-to-back writes before apply: last write wins.
- Divisor 0 means the channel is idle:
  - Applying 0 at terminal count forces clk_out<=0 (no toggle); tick is still 1 that cycle. From the next cycle counter=0 and tick=0.
  - While idle with pending=1, the shadow is applied on the next cycle, independent of en. counter restarts at 0 and clk_out starts from 0.
- Reset mid-operation: immediate return to reset values; any pending divisor is lost.
- en=0 freezes counter and clk_out. tick is 0 while en=0. On resuming, counting continues from the held count.
- Width rule: counter compare is against D-1 computed in DIV_W bits. D=0 never reaches the compare path.

Optional Feature:
- Macro: CLK_DIV_MULTI_SYNC_EN.
- With the macro: adds input port sync_clr (1 bit). When sync_clr=1 for a cycle:
  - all counters <=0, clk_out <=0, tick <=0;
  - pending shadows are applied immediately.
  - This phase-aligns all channels. sync_clr has priority over en and over terminal count.
- Without the macro: the port does not exist. Channels are aligned only by reset.

Decomposition:
- Package clk_div_pkg holds:
  - default constants DIV_W_DEF=16 and DEFAULT_DIV_DEF=333;
  - function ch_idx_w(CHANNELS) returning max(1, clog2).
- One sub-module is natural: clk_div_channel holds one counter, active/shadow divisor, pending flag and the output toggle.
  - Its inputs are en, its wr decode bit, wr_div and (optionally) sync_clr.
  - The top generates CHANNELS instances plus the write decoder.

Test Plan:
- Reset release, defaults, en=1 -> every clk_out first toggles at cycle 333 after release, period 666 cycles; tick=1 exactly on toggle cycles.
- Write ch1 wr_div=4 mid-period -> pending[1]=1 until ch1's next terminal count; thereafter toggles every 4 cycles; other channels unaffected.
- Write ch2 wr_div=1, then wr_div=0 -> ch2 toggles every cycle after apply; after the 0 applies, clk_out[2]=0 and tick[2]=0 permanently; a later write of 5 restarts it within 1 cycle, first toggle 5 cycles later.
- Write on exact terminal-count cycle (ch0 active=333, shadow=10, write 20) -> 10 applied now, pending[0] stays 1, 20 applied at the next terminal count (10 cycles later).
- en=0 for 50 cycles mid-count, then en=1 -> toggle delayed exactly 50 cycles; assert reset=0 mid-run with a pending write -> all outputs 0 asynchronously, pending cleared, DEFAULT_DIV restored.
- (CLK_DIV_MULTI_SYNC_EN) channels at divisors 3/7/11/333, pulse sync_clr -> all clk_out=0 next cycle; first toggles at 3/7/11/333 cycles after the pulse.
